// File: rtl/phy_tx.sv
// phy_tx: USB 2.0 full-speed transmit PHY.
// Serialises SIE bytes (LSB first) behind a SYNC pattern. Applies bit
// stuffing and NRZI encoding, and closes the packet with an EOP (SE0, SE0, J).
// Optional feature macro: PHY_TX_ABORT_EN. When defined, it adds tx_abort_i,
// which forces a bit-stuff error (8 bit periods with no transitions) and then
// an EOP.
module phy_tx #(
  parameter int BIT_SAMPLES = 4
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
`ifdef PHY_TX_ABORT_EN
  input  logic       tx_abort_i,
`endif
  output logic       tx_ready_o,
  output logic       tx_dp_o,
  output logic       tx_dn_o,
  output logic       tx_en_o
);

  localparam int CW = (BIT_SAMPLES > 1) ? $clog2(BIT_SAMPLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(BIT_SAMPLES - 1);

`ifdef PHY_TX_ABORT_EN
  typedef enum logic [2:0] {
    ST_IDLE, ST_SYNC, ST_DATA, ST_EOP, ST_ABORT
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE, ST_SYNC, ST_DATA, ST_EOP
  } state_t;
`endif

  state_t          state_q, state_d;
  logic [CW-1:0]   clk_cnt_q, clk_cnt_d;
  // SYNC/DATA: data bits of the current byte already on the line (0..8).
  // EOP/ABORT: bit periods already spent in that state.
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic [2:0]      stuff_cnt_q, stuff_cnt_d;
  logic            stuff_q, stuff_d;       // current bit period is a stuff bit
  logic [7:0]      shift_q, shift_d;       // bits still to send, LSB next
  logic            dp_q, dp_d;
  logic            dn_q, dn_d;
  logic            en_q, en_d;

  logic            bit_end;
  logic            stuff_due;
  logic            drive_bit;              // a new NRZI bit starts at this edge
  logic            drive_val;              // its data value (0 toggles the line)
  logic            to_eop;
  logic            ready;

  assign bit_end   = (clk_cnt_q == CNT_MAX);
  assign stuff_due = (stuff_cnt_q == 3'd6);

  // Next-state, bit sequencing, stuffing and NRZI line computation.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d     = state_q;
    clk_cnt_d   = clk_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    stuff_cnt_d = stuff_cnt_q;
    stuff_d     = stuff_q;
    shift_d     = shift_q;
    dp_d        = dp_q;
    dn_d        = dn_q;
    en_d        = en_q;
    drive_bit   = 1'b0;
    drive_val   = 1'b0;
    to_eop      = 1'b0;
    ready       = 1'b0;

    if (state_q != ST_IDLE) begin
      clk_cnt_d = bit_end ? '0 : clk_cnt_q + CW'(1);
    end

    case (state_q)
      ST_IDLE: begin
        clk_cnt_d = '0;
        if (tx_valid_i) begin
          // The first SYNC bit (a 0) goes out right away as K. The rest of
          // 8'h80 is queued in the shift register.
          state_d     = ST_SYNC;
          en_d        = 1'b1;
          dp_d        = 1'b0;
          dn_d        = 1'b1;
          shift_d     = 8'h40;
          bit_cnt_d   = 4'd1;
          stuff_cnt_d = 3'd0;
          stuff_d     = 1'b0;
        end
      end

      ST_SYNC, ST_DATA: begin
        if (bit_end) begin
`ifdef PHY_TX_ABORT_EN
          if (state_q == ST_DATA && tx_abort_i) begin
            state_d     = ST_ABORT;
            bit_cnt_d   = 4'd0;
            stuff_d     = 1'b0;
            stuff_cnt_d = 3'd0;
          end else
`endif
          if (bit_cnt_q == 4'd8 && !stuff_q) begin
            // Byte boundary: consume the next byte even if a stuff bit
            // has to go out before its first data bit.
            if (tx_valid_i) begin
              ready     = 1'b1;
              state_d   = ST_DATA;
              drive_bit = 1'b1;
              if (stuff_due) begin
                stuff_d   = 1'b1;
                shift_d   = tx_data_i;
                bit_cnt_d = 4'd0;
              end else begin
                drive_val = tx_data_i[0];
                stuff_d   = 1'b0;
                shift_d   = {1'b0, tx_data_i[7:1]};
                bit_cnt_d = 4'd1;
              end
            end else if (stuff_due) begin
              drive_bit = 1'b1;
              stuff_d   = 1'b1;
            end else begin
              to_eop = 1'b1;
            end
          end else if (bit_cnt_q == 4'd8) begin
            // Trailing stuff bit of the last byte is done.
            to_eop = 1'b1;
          end else if (stuff_due) begin
            drive_bit = 1'b1;
            stuff_d   = 1'b1;
          end else begin
            drive_bit = 1'b1;
            drive_val = shift_q[0];
            stuff_d   = 1'b0;
            shift_d   = {1'b0, shift_q[7:1]};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end

`ifdef PHY_TX_ABORT_EN
      ST_ABORT: begin
        // Hold the line for 8 bit periods: a deliberate stuffing violation.
        if (bit_end) begin
          if (bit_cnt_q == 4'd7) begin
            to_eop = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
`endif

      ST_EOP: begin
        if (bit_end) begin
          if (bit_cnt_q == 4'd0) begin
            bit_cnt_d = 4'd1;
          end else if (bit_cnt_q == 4'd1) begin
            bit_cnt_d = 4'd2;
            dp_d      = 1'b1;
            dn_d      = 1'b0;
          end else begin
            state_d     = ST_IDLE;
            en_d        = 1'b0;
            clk_cnt_d   = '0;
            bit_cnt_d   = 4'd0;
            stuff_cnt_d = 3'd0;
            stuff_d     = 1'b0;
            shift_d     = 8'h00;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // NRZI: a 0 swaps J<->K, a 1 holds the level. The stuff counter follows
    // every transmitted bit, stuff bits included (they are zeros).
    if (drive_bit) begin
      if (!drive_val) begin
        dp_d = dn_q;
        dn_d = dp_q;
      end
      stuff_cnt_d = drive_val ? stuff_cnt_q + 3'd1 : 3'd0;
    end

    if (to_eop) begin
      state_d     = ST_EOP;
      dp_d        = 1'b0;
      dn_d        = 1'b0;
      bit_cnt_d   = 4'd0;
      stuff_d     = 1'b0;
      stuff_cnt_d = 3'd0;
    end
  end

  // State and line registers; reset parks the bus at J with drivers off.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= ST_IDLE;
      clk_cnt_q   <= '0;
      bit_cnt_q   <= 4'd0;
      stuff_cnt_q <= 3'd0;
      stuff_q     <= 1'b0;
      shift_q     <= 8'h00;
      dp_q        <= 1'b1;
      dn_q        <= 1'b0;
      en_q        <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q     <= state_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      stuff_cnt_q <= stuff_cnt_d;
      stuff_q     <= stuff_d;
      shift_q     <= shift_d;
      dp_q        <= dp_d;
      dn_q        <= dn_d;
      en_q        <= en_d;
    end
  end

  assign tx_ready_o = ready;
  assign tx_dp_o    = dp_q;
  assign tx_dn_o    = dn_q;
  assign tx_en_o    = en_q;

endmodule

// File: tb/tb_phy_tx.sv
// tb_phy_tx: directed bench for phy_tx with hand-computed line sequences.
// Each packet is described by one character per bit period: J, K or 0 (SE0).
// A second string marks with 'r' the bit periods whose final clk must show
// tx_ready_o. Define PHY_TX_ABORT_EN to also exercise the abort path.
module tb_phy_tx;

  localparam int BS = 4;

  logic       clk_i = 1'b0;
  logic       rstn_i;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_dp;
  logic       tx_dn;
  logic       tx_en;
`ifdef PHY_TX_ABORT_EN
  logic       tx_abort;
  int         abort_at = -1;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  phy_tx #(.BIT_SAMPLES(BS)) dut (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .tx_data_i  (tx_data),
    .tx_valid_i (tx_valid),
`ifdef PHY_TX_ABORT_EN
    .tx_abort_i (tx_abort),
`endif
    .tx_ready_o (tx_ready),
    .tx_dp_o    (tx_dp),
    .tx_dn_o    (tx_dn),
    .tx_en_o    (tx_en)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] line_vec();
    return {28'd0, tx_en, tx_dp, tx_dn, tx_ready};
  endfunction

  // Idle bus: enabled=0, J, no ready.
  task automatic check_idle(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i);
      @(negedge clk_i);
      check($sformatf("%s idle %0d", tag, i), line_vec(), 32'h4);
    end
  endtask

  // Drives one packet from a negedge and checks every clk against the tables.
  // eop_mode: 0 = valid low in EOP, 1 = one-clk valid pulse in EOP,
  //           2 = valid raised in EOP and held (next packet follows at once).
  task automatic run_pkt(input string tag, input string lines, input string rdys,
                         input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                         input int nbytes, input int eop_mode);
    logic [7:0]  bytes [3];
    int          idx;
    bit          consumed;
    bit          eop_hit;
    int          p;
    byte         sym;
    logic [3:0]  exp_v;
    bytes[0] = b0;
    bytes[1] = b1;
    bytes[2] = b2;
    idx      = 0;
    consumed = 0;
    eop_hit  = 0;
    tx_data  = bytes[0];
    tx_valid = 1'b1;
    for (int k = 0; k < lines.len() * BS; k++) begin
      @(posedge clk_i);
      @(negedge clk_i);
      p   = k / BS;
      sym = lines[p];
      if (consumed) begin
        consumed = 0;
        idx++;
        if (idx < nbytes) tx_data = bytes[idx];
        else tx_valid = 1'b0;
      end
      if (sym == "0" && !eop_hit) begin
        eop_hit  = 1;
        tx_valid = (eop_mode != 0);
      end else if (eop_hit && eop_mode == 1) begin
        tx_valid = 1'b0;
      end
`ifdef PHY_TX_ABORT_EN
      tx_abort = (p == abort_at);
`endif
      exp_v = {1'b1, sym == "J", sym == "K", (k % BS == BS - 1) && (rdys[p] == "r")};
      check($sformatf("%s bit %0d clk %0d", tag, p, k), line_vec(), {28'd0, exp_v});
      if (tx_ready) consumed = 1;
    end
    check_idle(tag, (eop_mode == 2) ? 1 : 3);
  endtask

  initial begin
    rstn_i   = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
`ifdef PHY_TX_ABORT_EN
    tx_abort = 1'b0;
`endif
    @(negedge clk_i);
    check("reset values", line_vec(), 32'h4);
    tx_valid = 1'b1;
    @(negedge clk_i);
    check("reset ignores valid", line_vec(), 32'h4);
    tx_valid = 1'b0;
    rstn_i   = 1'b1;
    check_idle("post reset", 3);

    // 8'hA5: no stuffing, one ready at the end of SYNC.
    run_pkt("a5", "KJKJKJKKKJJKJJKK00J", ".......r...........",
            8'hA5, 8'h00, 8'h00, 1, 0);
    // 8'hFF: stuff after data bit 4; three 1s remain, so no stuff before EOP.
    run_pkt("ff", "KJKJKJKKKKKKKJJJJ00J", ".......r............",
            8'hFF, 8'h00, 8'h00, 1, 0);
    // 8'hFC: six trailing 1s, so the stuff bit goes out before EOP.
    run_pkt("fc", "KJKJKJKKJKKKKKKKJ00J", ".......r............",
            8'hFC, 8'h00, 8'h00, 1, 0);
    // FC,F0,03 back to back: ready at FC's last bit despite the stuff bit that
    // follows; the count carries from F0 into 03 (stuff before 03 bit 2).
    run_pkt("fc_f0_03", "KJKJKJKKJKKKKKKKJKJKJJJJJJJKJKJKJK00J",
            ".......r.......r........r............",
            8'hFC, 8'hF0, 8'h03, 3, 0);
    // Valid pulsed during EOP is ignored and the bus stays idle afterwards.
    run_pkt("eop_pulse", "KJKJKJKKKJJKJJKK00J", ".......r...........",
            8'hA5, 8'h00, 8'h00, 1, 1);
    // Valid raised in EOP and held: one idle clk, then SYNC of the next packet.
    run_pkt("eop_hold", "KJKJKJKKKJJKJJKK00J", ".......r...........",
            8'hA5, 8'h00, 8'h00, 1, 2);
    run_pkt("after_hold", "KJKJKJKKKKKKKJJJJ00J", ".......r............",
            8'hFF, 8'h00, 8'h00, 1, 0);

    // Reset in the middle of a data byte: the line drops at once, with no EOP.
    tx_data  = 8'hA5;
    tx_valid = 1'b1;
    for (int i = 0; i < 10 * BS + 2; i++) begin
      @(posedge clk_i);
      @(negedge clk_i);
    end
    check("mid-byte enabled before reset", {31'd0, tx_en}, 32'h1);
    rstn_i = 1'b0;
    #1;
    check("mid-byte reset same clk", line_vec(), 32'h4);
    tx_valid = 1'b0;
    @(negedge clk_i);
    check("mid-byte reset held", line_vec(), 32'h4);
    rstn_i = 1'b1;
    check_idle("after mid-byte reset", 2);
    run_pkt("restart", "KJKJKJKKKJJKJJKK00J", ".......r...........",
            8'hA5, 8'h00, 8'h00, 1, 0);

`ifdef PHY_TX_ABORT_EN
    // Abort at data bit 3 of 8'h00: 8 periods of constant K, then EOP.
    abort_at = 11;
    run_pkt("abort", "KJKJKJKKJKJKKKKKKKKK00J", ".......r...............",
            8'h00, 8'h55, 8'h00, 2, 0);
    abort_at = -1;
    tx_abort = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
